// File: rtl/i2c_mem_datapath.sv
// Byte datapath between the I2C bit layer and on-chip RAM: address/data capture, address
// auto-increment, write strobe and read serialiser. Optional macro: I2C_MEM_ADDR_WRAP_EN.
module i2c_mem_datapath #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_rise,
    input  logic              scl_fall,
    input  logic              sda_in,
    input  logic              read_mem_address,
    input  logic              write_mem,
    input  logic              wren,
    input  logic              increment_mem_address,
    input  logic              read_mem,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_write_bit,
    output logic              mem_read_bit,
    output logic              sda_tx,
    output logic              addr_overflow
);

`ifndef I2C_MEM_ADDR_WRAP_EN
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
`endif

    logic       cap_en;
    logic       cap_en_q;
    logic       cap_rise;
    logic [7:0] rx_shift;
    logic [3:0] bit_cnt;
    logic [7:0] rx_byte;
    logic       rx_shift_en;
    logic       byte_done;
    logic       inc_q;
    logic       inc_rise;
    logic       wren_q;
    logic       wren_q2;
    logic       read_mem_q1;
    logic       read_mem_q2;
    logic       tx_load;
    logic       tx_shift_en;
    logic [7:0] tx_shift;
    logic [2:0] tx_cnt;
    logic       tx_loaded;

    assign cap_en      = read_mem_address | write_mem;
    assign cap_rise    = cap_en & ~cap_en_q;
    // The arming cycle only clears; a bit arriving on that same cycle is not sampled.
    assign rx_shift_en = cap_en & cap_en_q & scl_rise & (bit_cnt != 4'd8);
    assign byte_done   = rx_shift_en & (bit_cnt == 4'd7);
    assign rx_byte     = {rx_shift[6:0], sda_in};
    assign inc_rise    = increment_mem_address & ~inc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_en_q <= 1'b0;
            rx_shift <= 8'h00;
            bit_cnt  <= 4'd0;
        end else begin
            cap_en_q <= cap_en;
            if (cap_rise) begin
                rx_shift <= 8'h00;
                bit_cnt  <= 4'd0;
            end else if (rx_shift_en) begin
                rx_shift <= rx_byte;
                bit_cnt  <= bit_cnt + 4'd1;
            end
        end
    end

    // Address register: a completed address byte takes priority over an increment edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_q         <= 1'b0;
            mem_addr      <= '0;
            mem_write_bit <= 1'b0;
            mem_read_bit  <= 1'b0;
            addr_overflow <= 1'b0;
        end else begin
            inc_q <= increment_mem_address;
            if (byte_done && read_mem_address) begin
                mem_addr      <= rx_byte[ADDR_W-1:0];
                mem_read_bit  <= rx_byte[7];
                mem_write_bit <= ~rx_byte[7];
                addr_overflow <= 1'b0;
            end else if (inc_rise) begin
`ifdef I2C_MEM_ADDR_WRAP_EN
                mem_addr <= mem_addr + 1'b1;
`else
                if (mem_addr == ADDR_MAX) begin
                    addr_overflow <= 1'b1;
                end else begin
                    mem_addr <= mem_addr + 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wdata <= 8'h00;
            wren_q    <= 1'b0;
            wren_q2   <= 1'b0;
        end else begin
            wren_q  <= wren;
            wren_q2 <= wren_q;
            if (byte_done && write_mem) begin
                mem_wdata <= rx_byte;
            end
        end
    end

    // One strobe per wren level, one cycle after it rises, built only from flops.
    assign mem_we = wren_q & ~wren_q2;

    // Load on read_mem's second cycle so the RAM output reflects the incremented address.
    assign tx_load     = read_mem & read_mem_q1 & ~read_mem_q2 & ~wren;
    assign tx_shift_en = read_mem & tx_loaded & scl_fall & (tx_cnt != 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            read_mem_q1 <= 1'b0;
            read_mem_q2 <= 1'b0;
            tx_shift    <= 8'hFF;
            tx_cnt      <= 3'd0;
            tx_loaded   <= 1'b0;
        end else begin
            read_mem_q1 <= read_mem;
            read_mem_q2 <= read_mem_q1;
            if (tx_load) begin
                tx_shift  <= mem_rdata;
                tx_cnt    <= 3'd0;
                tx_loaded <= 1'b1;
            end else if (!read_mem) begin
                tx_loaded <= 1'b0;
            end else if (tx_shift_en) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
                tx_cnt   <= tx_cnt + 3'd1;
            end
        end
    end

    assign sda_tx = tx_shift[7];

endmodule
